key_debounce: RTL and testbench
===============================

// Module: key_debounce
// PURPOSE
//  Front-end conditioner for a mechanical push-button. Synchronises the raw key,
//  rejects bounce, and emits a clean level plus one-cycle press/release strobes.
//  Sits directly upstream of the game logic: `press` drives the roll/generate
//    event, and a second instance conditions the reset button.
// PARAMETERS
//  DEB_CYCLES     16   consecutive stable synchronised samples needed to accept an edge (>=1)
//  CNT_BITS       16   debounce/repeat counter width; must hold max(DEB_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)-1
//  KEY_ACTIVE_LOW 0    1: raw key is pressed when 0; input is inverted before the synchroniser
//  REPEAT_DELAY   1000 HELD cycles before the first auto-repeat strobe (used only with KEY_AUTOREPEAT_EN)
//  REPEAT_PERIOD  250  cycles between subsequent auto-repeat strobes (used only with KEY_AUTOREPEAT_EN)
// PORTS
//  clk      in   1  single system clock; all state updates on the rising edge
//  r        in   1  synchronous reset, active-high
//  key      in   1  raw asynchronous button input
//  level    out  1  debounced key state, 1 = pressed (registered)
//  press    out  1  one-cycle strobe on accepted press (and on auto-repeat) (registered)
//  release  out  1  one-cycle strobe on accepted release (registered)
// BEHAVIOUR
//  - Reset (r=1 at an edge): sync FFs=0 (normalised), state=IDLE, counters=0, level=press=release=0.
//  - Synchroniser: 2 FFs on the polarity-normalised key; FSM uses ks = 2nd FF output.
//  - FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT; cnt is cleared on every state entry.
//   IDLE:         ks=1 -> PRESS_WAIT.
//   PRESS_WAIT:   ks=0 -> IDLE (glitch rejected, no strobe).
//                 ks=1 and cnt==DEB_CYCLES-1 -> HELD; level<=1; press<=1 for one cycle.
//                 otherwise cnt++.
//   HELD:         ks=0 -> RELEASE_WAIT; level stays 1.
//   RELEASE_WAIT: ks=1 -> HELD (bounce); no strobe; level stays 1.
//                 ks=0 and cnt==DEB_CYCLES-1 -> IDLE; level<=0; release<=1 for one cycle.
//                 otherwise cnt++.
//  - Latency: raw key stable high from sync-capture edge 0 -> press high in the cycle after
//    edge DEB_CYCLES+2. Release latency is identical.
//  - press and release are never high in the same cycle; each strobe lasts exactly one cycle.
//  - level changes in the same cycle as its strobe.
//  - A key pulse shorter than DEB_CYCLES synchronised samples produces no output change.
//  - Reset mid-operation: returns to IDLE immediately, with no release strobe.
//    If the key is still held, a fresh press is emitted after the full latency.
//  - r has priority over all other activity; cnt never wraps, because it is cleared at the terminal count.
// CONFIGURATION
//  KEY_AUTOREPEAT_EN defined:
//   - In HELD, a repeat counter runs. press re-strobes after REPEAT_DELAY cycles,
//     then every REPEAT_PERIOD cycles while in HELD.
//   - Entering RELEASE_WAIT or IDLE clears the repeat counter.
//   - A bounce back to HELD restarts the REPEAT_DELAY wait.
//  KEY_AUTOREPEAT_EN undefined:
//   - No repeat logic is synthesised; REPEAT_* parameters are ignored.
//   - Exactly one press per accepted hold.
// TESTING (DEB_CYCLES=4 unless noted)
//  1 r=1 for 2 cycles, key=0 -> level=press=release=0, state IDLE.
//  2 key 0->1 held 20 cycles -> press=1 for exactly 1 cycle after edge 6 from capture; level=1;
//    no further press (repeat off).
//  3 key high for 3 cycles then low -> no press, level stays 0.
//  4 while held, key bounces low 2 cycles -> no release; then low 10 cycles ->
//    one release strobe, level=0.
//  5 assert r while level=1 with key held -> outputs 0 next cycle; press re-strobes 7 cycles after r falls.
//  6 KEY_AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=3, key held 30 cycles -> press strobes at
//    accept+0, +8, +11, +14, ...; release strobe once after key falls.

Source files
------------

// File: rtl/key_debounce_if.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce_if
// Description : Signal bundle between a raw push-button source and the
//               key_debounce conditioner.
//                 key   - raw asynchronous button level (source -> debouncer)
//                 level - debounced key state, 1 = pressed
//                 press - one-cycle strobe on accepted press / auto-repeat
//                 rel   - one-cycle strobe on accepted release
//               "release" is a reserved word in SystemVerilog, so the release
//               strobe is carried on the member named rel.
//               master : the debouncer (consumes key, produces strobes)
//               slave  : the button side / downstream consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface key_debounce_if;
    logic key;
    logic level;
    logic press;
    logic rel;

    modport master (input key, output level, output press, output rel);
    modport slave  (output key, input level, input press, input rel);
endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Push-button conditioner. Polarity-normalises and
//               double-synchronises the raw key, debounces it with a
//               four-state FSM and emits a clean registered level plus
//               one-cycle press / release strobes.
// Ports       : clk - system clock, rising edge
//               r   - synchronous reset, active-high, priority over all else
//               kb  - key_debounce_if.master (key in; level, press, rel out)
// Options     : define KEY_AUTOREPEAT_EN to add press auto-repeat while held
//               (first repeat after REPEAT_DELAY cycles, then every
//               REPEAT_PERIOD cycles). Without it REPEAT_* are only range
//               checked and no repeat logic exists.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEB_CYCLES     = 16,
    parameter int CNT_BITS       = 16,
    parameter int KEY_ACTIVE_LOW = 0,
    parameter int REPEAT_DELAY   = 1000,
    parameter int REPEAT_PERIOD  = 250
) (
    input  logic           clk,
    input  logic           r,
    key_debounce_if.master kb
);

    // Largest value any counter must reach, for the elaboration-time check.
    localparam int c_need_a   = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
    localparam int c_need_max = (c_need_a > REPEAT_PERIOD) ? c_need_a : REPEAT_PERIOD;

    localparam logic [CNT_BITS-1:0] c_deb_last = CNT_BITS'(DEB_CYCLES - 1);

    if ((DEB_CYCLES < 1) || (longint'(c_need_max) > (longint'(1) << CNT_BITS))) begin : g_bad_params
        $error("key_debounce: DEB_CYCLES must be >= 1 and CNT_BITS wide enough for all counters");
    end

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic                w_key_norm;
    logic                r_sync1;
    logic                r_sync2;
    logic                w_ks;
    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] w_cnt_next;
    logic                r_level;
    logic                w_level_next;
    logic                r_press;
    logic                w_press_next;
    logic                r_rel;
    logic                w_rel_next;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_BITS-1:0] c_dly_last = CNT_BITS'(REPEAT_DELAY - 1);
    localparam logic [CNT_BITS-1:0] c_per_last = CNT_BITS'(REPEAT_PERIOD - 1);

    // r_rpt_phase = 0 while waiting out the initial delay, 1 once repeating.
    logic [CNT_BITS-1:0] r_rpt_cnt;
    logic [CNT_BITS-1:0] w_rpt_cnt_next;
    logic                r_rpt_phase;
    logic                w_rpt_phase_next;
`endif

    // Normalise so that 1 always means "pressed" from the synchroniser on.
    assign w_key_norm = (KEY_ACTIVE_LOW != 0) ? ~kb.key : kb.key;
    assign w_ks       = r_sync2;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        w_press_next = 1'b0;
        w_rel_next   = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        // Cleared everywhere except while staying in HELD, which also
        // restarts the initial delay after a bounce back into HELD.
        w_rpt_cnt_next   = '0;
        w_rpt_phase_next = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_ks) begin
                    w_state_next = S_PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end

            S_PRESS_WAIT: begin
                if (!w_ks) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_next = S_HELD;
                    w_cnt_next   = '0;
                    w_level_next = 1'b1;
                    w_press_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_HELD: begin
                if (!w_ks) begin
                    w_state_next = S_RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
`ifdef KEY_AUTOREPEAT_EN
                else begin
                    if (r_rpt_cnt == (r_rpt_phase ? c_per_last : c_dly_last)) begin
                        w_press_next     = 1'b1;
                        w_rpt_cnt_next   = '0;
                        w_rpt_phase_next = 1'b1;
                    end else begin
                        w_rpt_cnt_next   = r_rpt_cnt + 1'b1;
                        w_rpt_phase_next = r_rpt_phase;
                    end
                end
`else
                // A held key produces no further strobes.
`endif
            end

            S_RELEASE_WAIT: begin
                if (w_ks) begin
                    // Bounce: key came back before the release was accepted.
                    w_state_next = S_HELD;
                    w_cnt_next   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                    w_level_next = 1'b0;
                    w_rel_next   = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
        end else begin
            r_sync1 <= w_key_norm;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
            r_press <= w_press_next;
            r_rel   <= w_rel_next;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (r) begin
            r_rpt_cnt   <= '0;
            r_rpt_phase <= 1'b0;
        end else begin
            r_rpt_cnt   <= w_rpt_cnt_next;
            r_rpt_phase <= w_rpt_phase_next;
        end
    end
`endif

    assign kb.level = r_level;
    assign kb.press = r_press;
    assign kb.rel   = r_rel;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce
// Description : Self-checking bench for key_debounce (DEB_CYCLES = 4).
//               Reference model: a run-length rule - the debounced level
//               flips once the synchronised key has disagreed with it for
//               DEB_CYCLES+1 consecutive samples; auto-repeat is timed by
//               counting cycles spent held since acceptance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_debounce;

    localparam int DEB  = 4;
    localparam int RDLY = 8;
    localparam int RPER = 3;

    logic clk = 1'b0;
    logic r   = 1'b1;

    key_debounce_if kif ();

    key_debounce #(
        .DEB_CYCLES    (DEB),
        .CNT_BITS      (16),
        .KEY_ACTIVE_LOW(0),
        .REPEAT_DELAY  (RDLY),
        .REPEAT_PERIOD (RPER)
    ) dut (
        .clk(clk),
        .r  (r),
        .kb (kif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int n_press  = 0;
    int n_rel    = 0;

    // Reference model state
    bit m_p0, m_p1;          // two-stage sample delay of the key
    bit m_level, m_press, m_rel;
    int m_run;               // consecutive samples disagreeing with m_level
    int m_hc;                // cycles spent held since acceptance / bounce

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit k, input bit rr);
        bit ks;
        bit held_before;
        if (rr) begin
            m_p0 = 0; m_p1 = 0; m_level = 0; m_press = 0; m_rel = 0;
            m_run = 0; m_hc = 0;
        end else begin
            ks          = m_p1;
            held_before = m_level && (m_run == 0);
            m_press     = 0;
            m_rel       = 0;
            m_run       = (ks != m_level) ? m_run + 1 : 0;
            if (m_run == DEB + 1) begin
                m_level = ~m_level;
                if (m_level) m_press = 1;
                else         m_rel   = 1;
                m_run = 0;
                m_hc  = 0;
            end else if (held_before && ks) begin
                m_hc++;
`ifdef KEY_AUTOREPEAT_EN
                if (m_hc == RDLY || (m_hc > RDLY && ((m_hc - RDLY) % RPER) == 0))
                    m_press = 1;
`endif
            end else begin
                m_hc = 0;
            end
            m_p1 = m_p0;
            m_p0 = k;
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit k, input bit rr);
        kif.key = k;
        r       = rr;
        @(posedge clk);
        model_update(k, rr);
        #1;
        check("level",   int'(kif.level), int'(m_level));
        check("press",   int'(kif.press), int'(m_press));
        check("release", int'(kif.rel),   int'(m_rel));
        check("no_overlap", int'(kif.press & kif.rel), 0);
        n_press += int'(kif.press);
        n_rel   += int'(kif.rel);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    typedef struct {
        int hi1;
        int lo1;
        int hi2;
        int lo2;
        int exp_press;
        int exp_rel;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int idx;

        // Key pattern after reset, with expected strobe counts. Holds are
        // short enough that auto-repeat never fires in either build.
        tbl[0] = '{hi1: 1,  lo1: 15, hi2: 0, lo2: 0,  exp_press: 0, exp_rel: 0};
        tbl[1] = '{hi1: 3,  lo1: 15, hi2: 0, lo2: 0,  exp_press: 0, exp_rel: 0};
        tbl[2] = '{hi1: 4,  lo1: 15, hi2: 0, lo2: 0,  exp_press: 0, exp_rel: 0};
        tbl[3] = '{hi1: 5,  lo1: 15, hi2: 0, lo2: 0,  exp_press: 1, exp_rel: 1};
        tbl[4] = '{hi1: 12, lo1: 2,  hi2: 6, lo2: 15, exp_press: 1, exp_rel: 1};
        tbl[5] = '{hi1: 12, lo1: 4,  hi2: 6, lo2: 15, exp_press: 1, exp_rel: 1};
        tbl[6] = '{hi1: 12, lo1: 5,  hi2: 6, lo2: 15, exp_press: 2, exp_rel: 2};
        tbl[7] = '{hi1: 8,  lo1: 20, hi2: 7, lo2: 15, exp_press: 2, exp_rel: 2};

        kif.key = 1'b0;

        // Reset state
        do_reset();
        check("reset_level",   int'(kif.level), 0);
        check("reset_press",   int'(kif.press), 0);
        check("reset_release", int'(kif.rel),   0);

        // Held key: first press six edges after the capture edge.
        n_press = 0;
        idx     = -1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            if (kif.press && idx < 0) idx = i;
        end
        check("hold_press_edge", idx, 6);
        check("hold_level", int'(kif.level), 1);
`ifdef KEY_AUTOREPEAT_EN
        check("hold_press_count", n_press, 3);
`else
        check("hold_press_count", n_press, 1);
`endif

        // Reset while held: outputs clear, no release, fresh press later.
        n_rel = 0;
        step(1'b1, 1'b1);
        check("midrst_level", int'(kif.level), 0);
        check("midrst_press", int'(kif.press), 0);
        idx = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (kif.press && idx < 0) idx = i;
        end
        check("midrst_repress_edge", idx, 6);
        check("midrst_no_release", n_rel, 0);

        // Table of glitch / bounce patterns
        for (int t = 0; t < 8; t++) begin
            do_reset();
            n_press = 0;
            n_rel   = 0;
            for (int i = 0; i < tbl[t].hi1; i++) step(1'b1, 1'b0);
            for (int i = 0; i < tbl[t].lo1; i++) step(1'b0, 1'b0);
            for (int i = 0; i < tbl[t].hi2; i++) step(1'b1, 1'b0);
            for (int i = 0; i < tbl[t].lo2; i++) step(1'b0, 1'b0);
            check($sformatf("tbl%0d_press", t),   n_press, tbl[t].exp_press);
            check($sformatf("tbl%0d_release", t), n_rel,   tbl[t].exp_rel);
            check($sformatf("tbl%0d_level", t),   int'(kif.level), 0);
        end

        // Random runs of key levels with occasional resets
        for (int b = 0; b < 400; b++) begin
            bit v;
            bit rr;
            int len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            rr  = ($urandom_range(0, 39) == 0);
            for (int j = 0; j < len; j++) step(v, rr && (j == 0));
        end

`ifdef KEY_AUTOREPEAT_EN
        // Long hold: strobes at accept, +8, +11, +14, ... then one release.
        do_reset();
        n_press = 0;
        n_rel   = 0;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0);
        // accept at edge 6; held through edge 31 -> repeats at 14,17,...,29
        check("rpt_press_count", n_press, 7);
        check("rpt_release_count", n_rel, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
